// File: rtl/frequency_counter.sv
// frequency_counter: counts hysteresis-qualified rising zero crossings per trigger-gated interval
module frequency_counter #(
  parameter int HYSTERESIS  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] S_AXIS_IN_tdata,
  input  logic        S_AXIS_IN_tvalid,
  input  logic        trigger,
  output logic [31:0] M_AXIS_OUT_tdata,
  output logic        M_AXIS_OUT_tvalid,
  output logic [31:0] counter_output
);
  localparam logic signed [31:0] THR = 32'(HYSTERESIS);
  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;
  logic                   armed;
  logic                   primed;
  logic [31:0]            count;
  logic                   gate_edge;
  logic                   lo;
  logic                   hi;
  logic                   crossing;
  assign gate_edge = sync[SYNC_STAGES-1] & ~dly;
  assign lo        = S_AXIS_IN_tvalid && ($signed(S_AXIS_IN_tdata) <= -THR);
  assign hi        = S_AXIS_IN_tvalid && ($signed(S_AXIS_IN_tdata) >= THR);
  assign crossing  = armed & hi;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync              <= '0;
      dly               <= 1'b0;
      armed             <= 1'b0;
      primed            <= 1'b0;
      count             <= '0;
      counter_output    <= '0;
      M_AXIS_OUT_tdata  <= '0;
      M_AXIS_OUT_tvalid <= 1'b0;
    end else begin
      sync              <= {sync[SYNC_STAGES-2:0], trigger};
      dly               <= sync[SYNC_STAGES-1];
      armed             <= lo ? 1'b1 : crossing ? 1'b0 : armed;
      // a crossing coinciding with the gate edge opens the new interval
      count             <= gate_edge ? {31'd0, crossing} : (crossing && ~&count) ? count + 32'd1 : count;
      primed            <= primed | gate_edge;
      M_AXIS_OUT_tvalid <= gate_edge & primed;
      if (gate_edge && primed) begin
        counter_output   <= count;
        M_AXIS_OUT_tdata <= count;
      end
    end
endmodule

// File: tb/tb_frequency_counter.sv
// tb_frequency_counter: table-driven sine/gate scenarios plus hand-written edge and reset sequences
module tb_frequency_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic [31:0] cnt;
  int total = 0;
  int bad = 0;
  int q[$];
  int first_at;
  int calls;
  int half_sine[15] = '{0, 160, 310, 450, 570, 670, 730, 770, 770, 730, 670, 570, 450, 310, 160};
  typedef struct {
    string name;
    int    div;
    int    h;
    bit    alt;
    int    n;
    int    cmin;
    int    cmax;
    int    smin;
    int    smax;
  } vec_t;
  vec_t vecs[4];
  always #5 clk = ~clk;
  frequency_counter dut (
    .clk(clk),
    .rst(rst),
    .S_AXIS_IN_tdata(s_tdata),
    .S_AXIS_IN_tvalid(s_tvalid),
    .trigger(trigger),
    .M_AXIS_OUT_tdata(m_tdata),
    .M_AXIS_OUT_tvalid(m_tvalid),
    .counter_output(cnt)
  );
  task automatic check(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask
  function automatic int wave(input int s, input int div);
    int k;
    k = s % 30;
    return k < 15 ? half_sine[k] / div : -(half_sine[k-15] / div);
  endfunction
  // drive one beat, then observe the outputs after the edge that consumed it
  task automatic cyc(input logic v, input int d, input logic t);
    s_tvalid = v;
    s_tdata  = 32'(d);
    trigger  = t;
    @(negedge clk);
    calls++;
    if (m_tvalid) begin
      q.push_back(int'(m_tdata));
      if (q.size() == 1) first_at = calls;
      check("held_eq_tdata", int'(cnt), int'(m_tdata), int'(m_tdata));
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    repeat (3) cyc(1'b0, 0, 1'b0);
    rst = 1'b1;
  endtask
  task automatic run(input vec_t r);
    int s;
    int sum;
    int lim;
    logic v;
    int d;
    q.delete();
    calls = 0;
    first_at = -1;
    s = 0;
    lim = r.h + 2 * r.h * r.n + 6;
    for (int c = 0; c < lim; c++) begin
      v = r.alt ? (c % 2 == 0) : 1'b1;
      d = v ? wave(s, r.div) : ((c % 4 == 1) ? -1000 : 1000);
      if (v) s++;
      cyc(v, d, (c % (2 * r.h)) >= r.h);
    end
    check({r.name, "_pulses"}, q.size(), r.n, r.n);
    check({r.name, "_first_pub_at"}, first_at, 3 * r.h + 3, 3 * r.h + 3);
    sum = 0;
    foreach (q[i]) begin
      check({r.name, "_count"}, q[i], r.cmin, r.cmax);
      sum += q[i];
    end
    check({r.name, "_sum"}, sum, r.smin, r.smax);
  endtask
  initial begin
    vecs[0] = '{"steady", 1, 150, 1'b0, 4, 10, 10, 40, 40};
    vecs[1] = '{"short", 1, 25, 1'b0, 30, 1, 2, 49, 51};
    vecs[2] = '{"hyst", 16, 150, 1'b0, 3, 0, 0, 0, 0};
    vecs[3] = '{"valid", 1, 150, 1'b1, 3, 5, 5, 15, 15};
    @(negedge clk);
    calls = 0;
    q.delete();
    do_reset();
    check("rst_cnt", int'(cnt), 0, 0);
    check("rst_tdata", int'(m_tdata), 0, 0);
    check("rst_tvalid", int'(m_tvalid), 0, 0);
    repeat (20) cyc(1'b1, 0, 1'b0);
    check("idle_pulses", q.size(), 0, 0);
    check("idle_cnt", int'(cnt), 0, 0);
    foreach (vecs[i]) begin
      do_reset();
      run(vecs[i]);
    end
    do_reset();
    q.delete();
    repeat (4) cyc(1'b0, 0, 1'b1);
    repeat (6) cyc(1'b0, 0, 1'b0);
    check("prime_no_pub", q.size(), 0, 0);
    repeat (2) begin
      cyc(1'b1, -100, 1'b0);
      cyc(1'b1, 100, 1'b0);
    end
    cyc(1'b1, -100, 1'b0);
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    check("lat_before", int'(m_tvalid), 0, 0);
    cyc(1'b1, 100, 1'b1);
    check("edge_tvalid", int'(m_tvalid), 1, 1);
    check("edge_old_count", int'(m_tdata), 2, 2);
    cyc(1'b0, 0, 1'b1);
    check("pulse_one_cycle", int'(m_tvalid), 0, 0);
    repeat (4) cyc(1'b0, 0, 1'b0);
    repeat (3) cyc(1'b0, 0, 1'b1);
    check("aligned_tvalid", int'(m_tvalid), 1, 1);
    check("aligned_new_count", int'(m_tdata), 1, 1);
    check("aligned_held", int'(cnt), 1, 1);
    cyc(1'b0, 0, 1'b0);
    repeat (3) begin
      cyc(1'b1, -100, 1'b0);
      cyc(1'b1, 100, 1'b0);
    end
    #2 rst = 1'b0;
    #1;
    check("async_rst_cnt", int'(cnt), 0, 0);
    check("async_rst_tdata", int'(m_tdata), 0, 0);
    check("async_rst_tvalid", int'(m_tvalid), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
